// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered control-decode stage with mem stall, flush, halt and retire counter
module ctrl_decode_stage #(
    parameter int IW        = 9,
    parameter int REG_W     = 3,
    parameter int MEM_STALL = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [IW-1:0]    instr,
    output logic             instr_ready,
    input  logic             flush,
    input  logic             out_ready,
    output logic             ctrl_valid,
    output logic             branch,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             reg_write,
    output logic             immediate,
    output logic             zero_store,
    output logic             halt,
    output logic [REG_W-1:0] wr_index,
    output logic             halted,
    output logic [CNT_W-1:0] insn_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam int SC_W = (MEM_STALL > 1) ? $clog2(MEM_STALL + 1) : 1;

    logic [1:0]       r_state;
    logic [SC_W-1:0]  r_stall_cnt;
    logic             r_valid;
    logic [6:0]       r_bundle;
    logic [REG_W-1:0] r_index;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_op;
    logic             w_sub;
    logic [6:0]       w_dec;
    logic             w_accept;
    logic             w_unused_bits;

    assign w_op          = instr[IW-1:IW-2];
    assign w_sub         = instr[0];
    assign w_unused_bits = ^instr[IW-3:REG_W+1];

    // bundle bit order: branch, mem_to_reg, mem_write, reg_write, immediate, zero_store, halt
    always_comb begin
        w_dec = 7'b0;
        case (w_op)
            2'b00: w_dec = w_sub ? 7'b0001000 : 7'b0001010;
            2'b01: w_dec = w_sub ? 7'b0010000 : 7'b0101010;
            2'b10: w_dec = 7'b1000000;
            default: w_dec = w_sub ? 7'b0000001 : 7'b0001100;
        endcase
    end

    assign instr_ready = (r_state == ST_RUN) && !flush && (!r_valid || out_ready);
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_valid     <= 1'b0;
            r_bundle    <= '0;
            r_index     <= '0;
            r_count     <= '0;
        end else if (flush && (r_state != ST_HALTED)) begin
            // taken branch: drop the held bundle and abandon any memory stall
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_valid     <= 1'b0;
            r_bundle    <= '0;
            r_index     <= '0;
        end else begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_bundle <= w_dec;
                r_index  <= instr[REG_W:1];
                r_count  <= r_count + 1'b1;
                if (w_dec[0]) begin
                    r_state <= ST_HALTED;
                end else if ((w_op == 2'b01) && (MEM_STALL > 0)) begin
                    r_state     <= ST_MEMWAIT;
                    r_stall_cnt <= SC_W'(MEM_STALL);
                end
            end else if (out_ready) begin
                r_valid  <= 1'b0;
                r_bundle <= '0;
                r_index  <= '0;
            end
            if (r_state == ST_MEMWAIT) begin
                r_stall_cnt <= r_stall_cnt - 1'b1;
                if (r_stall_cnt == SC_W'(1)) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign ctrl_valid = r_valid;
    assign branch     = r_bundle[6];
    assign mem_to_reg = r_bundle[5];
    assign mem_write  = r_bundle[4];
    assign reg_write  = r_bundle[3];
    assign immediate  = r_bundle[2];
    assign zero_store = r_bundle[1];
    assign halt       = r_bundle[0];
    assign wr_index   = r_index;
    assign halted     = (r_state == ST_HALTED);
    assign insn_count = r_count;

endmodule
